// File: rtl/csr_stream_loader_pkg.sv
// Shared types and default sizing for the CSR stream loader and the diagonal checker.
package csr_stream_loader_pkg;

  localparam int unsigned CSR_WIDTH = 10;
  localparam int unsigned CSR_SIZE  = 1024;

  typedef enum logic [2:0] {
    HDR_ROWS,
    HDR_NNZ,
    LOAD_OFF,
    LOAD_COL,
    LOADED,
    ERR
  } state_t;

  function automatic logic takes_words(input state_t s);
    return (s == HDR_ROWS) || (s == HDR_NNZ) || (s == LOAD_OFF) || (s == LOAD_COL);
  endfunction

endpackage

// File: rtl/csr_pack_array.sv
// WIDTH x SIZE register array written one element at a time, exposed as a flat bus.
module csr_pack_array #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned SIZE  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [WIDTH-1:0]        addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH*SIZE-1:0]   data
);

  // Address compare per element keeps out-of-range addresses harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < SIZE; k++) begin
        if (addr == WIDTH'(k)) data[k*WIDTH +: WIDTH] <= wdata;
      end
    end
  end

endmodule

// File: rtl/csr_stream_loader.sv
// Loads a header/offsets/colIdx word stream into packed buses and holds the checker in reset until done.
module csr_stream_loader
  import csr_stream_loader_pkg::*;
#(
  parameter int unsigned WIDTH = CSR_WIDTH,
  parameter int unsigned SIZE  = CSR_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    restart,
  output logic [WIDTH*SIZE-1:0]   offsets,
  output logic [WIDTH*SIZE-1:0]   colIdx,
  output logic [WIDTH-1:0]        numRow,
  output logic [WIDTH-1:0]        NNZ,
  output logic                    loaded,
  output logic                    chk_rst_n,
  output logic                    err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] idx, idx_nxt;
  logic             accept, too_big;
  logic             rows_we, nnz_we, off_we, col_we;

  assign accept    = in_valid && in_ready;
  assign too_big   = 32'(in_data) > SIZE;
  assign chk_rst_n = loaded;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rows_we   = 1'b0;
    nnz_we    = 1'b0;
    off_we    = 1'b0;
    col_we    = 1'b0;
    case (state)
      HDR_ROWS: if (accept) begin
        rows_we   = 1'b1;
        state_nxt = too_big ? ERR : HDR_NNZ;
      end
      HDR_NNZ: if (accept) begin
        nnz_we  = 1'b1;
        idx_nxt = '0;
        if (too_big)            state_nxt = ERR;
        else if (numRow == '0)  state_nxt = (in_data == '0) ? LOADED : LOAD_COL;
        else                    state_nxt = LOAD_OFF;
      end
      LOAD_OFF: if (accept) begin
        off_we = 1'b1;
        if (idx == numRow - WIDTH'(1)) begin
          idx_nxt   = '0;
          state_nxt = (NNZ != '0) ? LOAD_COL : LOADED;
        end else begin
          idx_nxt = idx + WIDTH'(1);
        end
      end
      LOAD_COL: if (accept) begin
        col_we = 1'b1;
        if (idx == NNZ - WIDTH'(1)) begin
          idx_nxt   = '0;
          state_nxt = LOADED;
        end else begin
          idx_nxt = idx + WIDTH'(1);
        end
      end
      LOADED, ERR: if (restart) state_nxt = HDR_ROWS;
      default: state_nxt = HDR_ROWS;
    endcase
  end

  // Status outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HDR_ROWS;
      idx      <= '0;
      numRow   <= '0;
      NNZ      <= '0;
      in_ready <= 1'b1;
      loaded   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      in_ready <= takes_words(state_nxt);
      loaded   <= (state_nxt == LOADED);
      err      <= (state_nxt == ERR);
      if (rows_we) numRow <= in_data;
      if (nnz_we)  NNZ    <= in_data;
    end
  end

  csr_pack_array #(.WIDTH(WIDTH), .SIZE(SIZE)) u_offsets (
    .clk   (clk),
    .rst   (rst),
    .we    (off_we),
    .addr  (idx),
    .wdata (in_data),
    .data  (offsets)
  );

  csr_pack_array #(.WIDTH(WIDTH), .SIZE(SIZE)) u_colidx (
    .clk   (clk),
    .rst   (rst),
    .we    (col_we),
    .addr  (idx),
    .wdata (in_data),
    .data  (colIdx)
  );

endmodule
